// File: rtl/posit_to_pif_pipe_if.sv
// Operand ingress/egress bundle for posit_to_pif_pipe: posit input stream and PIF output stream.
interface posit_to_pif_pipe_if #(
    parameter int N  = 8,
    parameter int ES = 0
);
    localparam int TE_SIZE   = ES + $clog2(N) + 1;
    localparam int MANT_SIZE = N - ES - 2;
    localparam int PIF_SIZE  = 1 + TE_SIZE + MANT_SIZE;

    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_posit;
    logic                out_valid;
    logic                out_ready;
    logic [PIF_SIZE-1:0] out_pif;
    logic                out_zero;
    logic                out_nar;

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_pif, out_zero, out_nar
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_pif, out_zero, out_nar
    );
endinterface

// File: rtl/posit_to_pif_pipe.sv
// Two-stage elastic posit -> PIF converter {sign, te, mant} with zero/NaR flags.
// Optional output-transfer statistics counters when POSIT_TO_PIF_STATS_EN is defined.
module posit_to_pif_pipe #(
    parameter int N  = 8,
    parameter int ES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    posit_to_pif_pipe_if.slave  bus
`ifdef POSIT_TO_PIF_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         stat_count,
    output logic [15:0]         stat_zero,
    output logic [15:0]         stat_nar
`endif
);
    localparam int TE_SIZE   = ES + $clog2(N) + 1;
    localparam int MANT_SIZE = N - ES - 2;
    localparam int PIF_SIZE  = 1 + TE_SIZE + MANT_SIZE;
    localparam int RUN_W     = $clog2(N) + 1;

    localparam logic [N-1:0]        NAR_POSIT = {1'b1, {(N-1){1'b0}}};
    localparam logic [PIF_SIZE-1:0] NAR_PIF   = {1'b1, {(PIF_SIZE-1){1'b0}}};
    localparam logic [RUN_W-1:0]    RUN_ONE   = RUN_W'(1);
    localparam logic [TE_SIZE-1:0]  TE_ONE    = TE_SIZE'(1);
    localparam logic [TE_SIZE-1:0]  TE_ZERO   = '0;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q,  s1_sign_d;
    logic [N-2:0]        s1_body_q,  s1_body_d;
    logic                s1_zero_q,  s1_zero_d;
    logic                s1_nar_q,   s1_nar_d;

    logic                s2_valid_q, s2_valid_d;
    logic [PIF_SIZE-1:0] s2_pif_q,   s2_pif_d;
    logic                s2_zero_q,  s2_zero_d;
    logic                s2_nar_q,   s2_nar_d;

    logic                s1_load;
    logic                s2_load;
    logic [N-1:0]        in_abs;

    logic                rc;
    logic                run_done;
    logic [RUN_W-1:0]    run;
    logic [TE_SIZE-1:0]  run_te;
    logic [TE_SIZE-1:0]  k;
    logic [TE_SIZE-1:0]  e_bits;
    logic [TE_SIZE-1:0]  te;
    logic [N-2:0]        rem;
    logic [N-1:0]        frac_ext;
    logic [N-1:0]        mant_full;
    logic [MANT_SIZE-1:0] mant;
    logic [PIF_SIZE-1:0] pif_dec;

    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign in_abs  = bus.in_posit[N-1] ? (~bus.in_posit + N'(1)) : bus.in_posit;

    // Regime decode: count the leading run of bits equal to the first body bit.
    always_comb begin
        rc       = s1_body_q[N-2];
        run      = '0;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done) begin
                if (s1_body_q[i] == rc) begin
                    run = run + RUN_ONE;
                end else begin
                    run_done = 1'b1;
                end
            end
        end
        run_te    = TE_SIZE'(run);
        k         = rc ? (run_te - TE_ONE) : (TE_ZERO - run_te);
        // Drop regime plus terminating bit; a full-length run has no terminator and shifts everything out.
        rem       = s1_body_q << (run + RUN_ONE);
        e_bits    = TE_SIZE'(rem >> (N - 1 - ES));
        te        = (k << ES) | e_bits;
        frac_ext  = {1'b1, rem << ES};
        mant_full = frac_ext >> (ES + 2);
        mant      = mant_full[MANT_SIZE-1:0];
        if (s1_zero_q) begin
            pif_dec = '0;
        end else if (s1_nar_q) begin
            pif_dec = NAR_PIF;
        end else begin
            pif_dec = {s1_sign_q, te, mant};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_body_d  = s1_body_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        s2_valid_d = s2_valid_q;
        s2_pif_d   = s2_pif_q;
        s2_zero_d  = s2_zero_q;
        s2_nar_d   = s2_nar_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = bus.in_posit[N-1];
                s1_body_d = in_abs[N-2:0];
                s1_zero_d = (bus.in_posit == '0);
                s1_nar_d  = (bus.in_posit == NAR_POSIT);
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pif_d  = pif_dec;
                s2_zero_d = s1_zero_q;
                s2_nar_d  = s1_nar_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_body_q  <= '0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pif_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_body_q  <= s1_body_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s2_valid_q <= s2_valid_d;
            s2_pif_q   <= s2_pif_d;
            s2_zero_q  <= s2_zero_d;
            s2_nar_q   <= s2_nar_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_pif   = s2_pif_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_nar   = s2_nar_q;

`ifdef POSIT_TO_PIF_STATS_EN
    logic        out_xfer;
    logic [31:0] stat_count_q, stat_count_d;
    logic [15:0] stat_zero_q,  stat_zero_d;
    logic [15:0] stat_nar_q,   stat_nar_d;

    assign out_xfer = s2_valid_q && bus.out_ready;

    always_comb begin
        stat_count_d = stat_count_q;
        stat_zero_d  = stat_zero_q;
        stat_nar_d   = stat_nar_q;
        if (stat_clr) begin
            stat_count_d = '0;
            stat_zero_d  = '0;
            stat_nar_d   = '0;
        end else if (out_xfer) begin
            stat_count_d = stat_count_q + 32'd1;
            if (s2_zero_q) stat_zero_d = stat_zero_q + 16'd1;
            if (s2_nar_q)  stat_nar_d  = stat_nar_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_q <= '0;
            stat_zero_q  <= '0;
            stat_nar_q   <= '0;
        end else begin
            stat_count_q <= stat_count_d;
            stat_zero_q  <= stat_zero_d;
            stat_nar_q   <= stat_nar_d;
        end
    end

    assign stat_count = stat_count_q;
    assign stat_zero  = stat_zero_q;
    assign stat_nar   = stat_nar_q;
`endif
endmodule

// File: tb/tb_posit_to_pif_pipe.sv
// Directed bench for posit_to_pif_pipe at N=8, ES=0 (PIF = {sign, te[3:0], mant[5:0]}).
module tb_posit_to_pif_pipe;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    posit_to_pif_pipe_if #(.N(8), .ES(0)) bus ();

`ifdef POSIT_TO_PIF_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_count;
    logic [15:0] stat_zero;
    logic [15:0] stat_nar;
`endif

    posit_to_pif_pipe #(.N(8), .ES(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef POSIT_TO_PIF_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_count (stat_count),
        .stat_zero  (stat_zero),
        .stat_nar   (stat_nar)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_posit  = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vec_cnt++;
        if (bus.out_pif !== 11'h000) begin err_cnt++; $display("FAIL reset_out_pif got %h want 000", bus.out_pif); end
        vec_cnt++;
        if (bus.out_zero !== 1'b0 || bus.out_nar !== 1'b0) begin
            err_cnt++; $display("FAIL reset_flags got zero=%b nar=%b want 0/0", bus.out_zero, bus.out_nar);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_posit  = 8'h40;
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_latency1 got out_valid=%b want 0", bus.out_valid); end
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_pif !== 11'h020 || bus.out_zero !== 1'b0 || bus.out_nar !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_one got v=%b pif=%h z=%b n=%b want 1/020/0/0",
                     bus.out_valid, bus.out_pif, bus.out_zero, bus.out_nar);
        end
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drain got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vin  [0:3];
        logic [10:0] vexp [0:3];
        vin  = '{8'h60, 8'h48, 8'hC0, 8'h01};
        vexp = '{11'h060, 11'h028, 11'h420, 11'h2A0};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c < 6) begin
                vec_cnt++;
                if (bus.out_valid !== 1'b1 || bus.out_pif !== vexp[c-2]) begin
                    err_cnt++;
                    $display("FAIL b2b_item%0d got v=%b pif=%h want 1/%h", c - 2, bus.out_valid, bus.out_pif, vexp[c-2]);
                end
            end else begin
                vec_cnt++;
                if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle%0d got out_valid=%b want 0", c, bus.out_valid); end
            end
            if (c < 4) begin
                bus.in_valid = 1'b1;
                bus.in_posit = vin[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_boundary();
        logic [7:0]  vin  [0:6];
        logic [10:0] vexp [0:6];
        logic        zexp [0:6];
        logic        nexp [0:6];
        vin  = '{8'h00, 8'h80, 8'h7F, 8'h81, 8'h01, 8'hFF, 8'h3F};
        vexp = '{11'h000, 11'h400, 11'h1A0, 11'h5A0, 11'h2A0, 11'h6A0, 11'h3FF};
        zexp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        nexp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c >= 2) begin
                vec_cnt++;
                if (bus.out_valid !== 1'b1 || bus.out_pif !== vexp[c-2] ||
                    bus.out_zero !== zexp[c-2] || bus.out_nar !== nexp[c-2]) begin
                    err_cnt++;
                    $display("FAIL boundary_%h got v=%b pif=%h z=%b n=%b want 1/%h/%b/%b", vin[c-2],
                             bus.out_valid, bus.out_pif, bus.out_zero, bus.out_nar, vexp[c-2], zexp[c-2], nexp[c-2]);
                end
            end
            if (c < 7) begin
                bus.in_valid = 1'b1;
                bus.in_posit = vin[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [7:0]  src [0:3];
        logic [10:0] exp_pif [0:3];
        int idx;
        int rx;
        src     = '{8'h40, 8'h60, 8'h48, 8'hC0};
        exp_pif = '{11'h020, 11'h060, 11'h028, 11'h420};
        idx = 0;
        rx  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_posit = src[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                vec_cnt++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pif !== 11'h020) begin
                    err_cnt++;
                    $display("FAIL stall_hold%0d got rdy=%b v=%b pif=%h want 0/1/020",
                             cyc, bus.in_ready, bus.out_valid, bus.out_pif);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                vec_cnt++;
                if (rx >= 4) begin
                    err_cnt++; $display("FAIL stall_extra got pif=%h want no item", bus.out_pif);
                end else if (bus.out_pif !== exp_pif[rx]) begin
                    err_cnt++; $display("FAIL stall_order%0d got pif=%h want %h", rx, bus.out_pif, exp_pif[rx]);
                end
                rx++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) idx++;
            if (cyc == 4) begin
                vec_cnt++;
                if (idx != 2) begin err_cnt++; $display("FAIL stall_accepts got %0d want 2", idx); end
            end
            tick();
            if (rx >= 4 && idx >= 4) break;
        end
        vec_cnt++;
        if (rx != 4) begin err_cnt++; $display("FAIL stall_count got %0d want 4", rx); end
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_dup got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_posit  = 8'h48;
        tick();
        bus.in_posit  = 8'h60;
        tick();
        bus.in_valid  = 1'b0;
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_pif !== 11'h028) begin
            err_cnt++; $display("FAIL rstmid_pre got v=%b pif=%h want 1/028", bus.out_valid, bus.out_pif);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_pif !== 11'h000) begin
            err_cnt++; $display("FAIL rstmid_flush got v=%b pif=%h want 0/000", bus.out_valid, bus.out_pif);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vec_cnt++;
            if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stale%0d got out_valid=%b want 0", c, bus.out_valid); end
        end
        bus.in_valid = 1'b1;
        bus.in_posit = 8'hC0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_pif !== 11'h420) begin
            err_cnt++; $display("FAIL rstmid_recover got v=%b pif=%h want 1/420", bus.out_valid, bus.out_pif);
        end
        tick();
    endtask

`ifdef POSIT_TO_PIF_STATS_EN
    task automatic test_stats();
        logic [7:0] vin [0:9];
        vin = '{8'h00, 8'h40, 8'h80, 8'h60, 8'h00, 8'h48, 8'hC0, 8'h01, 8'h7F, 8'hFF};
        bus.out_ready = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        vec_cnt++;
        if (stat_count !== 32'd0) begin err_cnt++; $display("FAIL stats_clr0 got %0d want 0", stat_count); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_posit = vin[i];
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        vec_cnt++;
        if (stat_count !== 32'd10 || stat_zero !== 16'd2 || stat_nar !== 16'd1) begin
            err_cnt++; $display("FAIL stats_counts got %0d/%0d/%0d want 10/2/1", stat_count, stat_zero, stat_nar);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        vec_cnt++;
        if (stat_count !== 32'd0 || stat_zero !== 16'd0 || stat_nar !== 16'd0) begin
            err_cnt++; $display("FAIL stats_clr got %0d/%0d/%0d want 0/0/0", stat_count, stat_zero, stat_nar);
        end
    endtask
`endif

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
`ifdef POSIT_TO_PIF_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary();
        test_stall();
        test_reset_midstream();
`ifdef POSIT_TO_PIF_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end
endmodule
